// File: rtl/tick_meter_pkg.sv
// -----------------------------------------------------------------------------
// tick_meter_pkg
// Shared types and default parameters for the tick period meter.
//   tm_state_t     : measurement FSM state (IDLE, COUNTING)
//   TM_WIDTH_DEF   : default counter / result width
//   TM_TIMEOUT_DEF : default stall threshold in clk cycles
// -----------------------------------------------------------------------------
package tick_meter_pkg;

    localparam int unsigned TM_WIDTH_DEF   = 32;
    localparam int unsigned TM_TIMEOUT_DEF = 1_000_000;

    typedef enum logic {
        IDLE     = 1'b0,  // waiting for the first tick of a measurement
        COUNTING = 1'b1   // measuring the distance to the next tick
    } tm_state_t;

endpackage

// File: rtl/tick_period_meter_if.sv
// -----------------------------------------------------------------------------
// tick_period_meter_if
// Valid/ready result channel of the tick period meter.
//   period       : measured cycles between two ticks
//   period_valid : period holds an unconsumed result
//   period_ready : consumer accepts period (sampled at the clock edge)
// Modports:
//   master : the meter (drives period / period_valid)
//   slave  : the consumer (drives period_ready)
// -----------------------------------------------------------------------------
interface tick_period_meter_if
    import tick_meter_pkg::*;
#(
    parameter int unsigned WIDTH = TM_WIDTH_DEF
) ();

    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             period_ready;

    modport master (
        output period,
        output period_valid,
        input  period_ready
    );

    modport slave (
        input  period,
        input  period_valid,
        output period_ready
    );

endinterface

// File: rtl/period_result_reg.sv
// -----------------------------------------------------------------------------
// period_result_reg
// One-entry result register with valid/ready output and a sticky overrun flag.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clear         : synchronous soft clear (drops the result, clears overrun)
//   capture       : a new period is offered this cycle
//   capture_val   : the period being offered
//   period_ready  : consumer accepts the held result
//   period        : held result
//   period_valid  : held result not yet consumed
//   overrun       : sticky, a captured value was dropped
// -----------------------------------------------------------------------------
module period_result_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_val,
    input  logic             period_ready,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] period_q,  period_d;
    logic             valid_q,   valid_d;
    logic             overrun_q, overrun_d;
    logic             transfer;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        transfer  = valid_q && period_ready;

        if (clear) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (transfer) begin
                valid_d = 1'b0;
            end
            if (capture) begin
                // The slot is free if empty or emptied by this cycle's transfer.
                if (valid_q && !transfer) begin
                    overrun_d = 1'b1;
                end else begin
                    period_d = capture_val;
                    valid_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: rtl/tick_period_meter.sv
// -----------------------------------------------------------------------------
// tick_period_meter
// Counts clk cycles between successive tick pulses and reports each period
// over a valid/ready channel. Declares the source stalled when no tick arrives
// within TIMEOUT cycles.
//   clk, reset_n  : clock, asynchronous active-low reset
//   tick_in       : tick pulse, each high cycle is one tick
//   clear         : synchronous soft clear (state, result, flags, stats)
//   res           : result channel (period / period_valid / period_ready)
//   timeout       : sticky, tick source stalled
//   overrun       : sticky, a result was dropped
//   period_min    : smallest period seen     (TICK_METER_STATS_EN only)
//   period_max    : largest period seen      (TICK_METER_STATS_EN only)
// Optional feature: define TICK_METER_STATS_EN to build the min/max stats.
// -----------------------------------------------------------------------------
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int unsigned WIDTH   = TM_WIDTH_DEF,
    parameter int unsigned TIMEOUT = TM_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick_in,
    input  logic                    clear,
    tick_period_meter_if.master     res,
    output logic                    timeout,
    output logic                    overrun
`ifdef TICK_METER_STATS_EN
    ,
    output logic [WIDTH-1:0]        period_min,
    output logic [WIDTH-1:0]        period_max
`endif
);

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    tm_state_t        state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] cnt_inc;
    logic             capture;

    // TIMEOUT <= 2^WIDTH-1 keeps cnt below TIMEOUT, so cnt+1 never overflows.
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        capture   = 1'b0;

        if (clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_in) begin
                        state_d = COUNTING;
                        cnt_d   = '0;
                    end
                end
                COUNTING: begin
                    // A tick on the threshold cycle wins over the timeout.
                    if (tick_in) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_inc == TIMEOUT_W) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    period_result_reg #(
        .WIDTH (WIDTH)
    ) u_result (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .capture      (capture),
        .capture_val  (cnt_inc),
        .period_ready (res.period_ready),
        .period       (res.period),
        .period_valid (res.period_valid),
        .overrun      (overrun)
    );

`ifdef TICK_METER_STATS_EN
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;

    // Stats see every capture, including ones the result register drops.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear) begin
            min_d = '1;
            max_d = '0;
        end else if (capture) begin
            if (cnt_inc < min_q) min_d = cnt_inc;
            if (cnt_inc > max_q) max_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// -----------------------------------------------------------------------------
// tb_tick_period_meter
// Directed bench for tick_period_meter. Instance dut_a (TIMEOUT=8) covers
// steady ticks, back-to-back ticks, overrun, timeout, clear and reset.
// Instance dut_b (TIMEOUT=100) covers longer periods and, with
// TICK_METER_STATS_EN defined, the min/max stats.
// Expected periods are queued when the closing tick is driven and compared
// when the result is handed over (valid && ready before an edge).
// -----------------------------------------------------------------------------
module tb_tick_period_meter;
    import tick_meter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic tick_a, clear_a, tick_b, clear_b;
    logic timeout_a, overrun_a, timeout_b, overrun_b;
`ifdef TICK_METER_STATS_EN
    logic [31:0] min_a, max_a, min_b, max_b;
`endif

    tick_period_meter_if #(.WIDTH(32)) res_a ();
    tick_period_meter_if #(.WIDTH(32)) res_b ();

    tick_period_meter #(.WIDTH(32), .TIMEOUT(8)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_in    (tick_a),
        .clear      (clear_a),
        .res        (res_a),
        .timeout    (timeout_a),
        .overrun    (overrun_a)
`ifdef TICK_METER_STATS_EN
        ,
        .period_min (min_a),
        .period_max (max_a)
`endif
    );

    tick_period_meter #(.WIDTH(32), .TIMEOUT(100)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_in    (tick_b),
        .clear      (clear_b),
        .res        (res_b),
        .timeout    (timeout_b),
        .overrun    (overrun_b)
`ifdef TICK_METER_STATS_EN
        ,
        .period_min (min_b),
        .period_max (max_b)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive dut_a inputs for one cycle; a result handed over at the coming
    // edge is compared against the scoreboard first.
    task automatic step_a(input logic t, input logic c, input logic r);
        tick_a = t;
        clear_a = c;
        res_a.period_ready = r;
        if (res_a.period_valid === 1'b1 && r) begin
            chk("a_sb_depth", 64'(exp_a.size() > 0), 64'd1);
            if (exp_a.size() > 0) chk("a_period", 64'(res_a.period), 64'(exp_a.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic t, input logic c, input logic r);
        tick_b = t;
        clear_b = c;
        res_b.period_ready = r;
        if (res_b.period_valid === 1'b1 && r) begin
            chk("b_sb_depth", 64'(exp_b.size() > 0), 64'd1);
            if (exp_b.size() > 0) chk("b_period", 64'(res_b.period), 64'(exp_b.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        tick_a = 1'b0; clear_a = 1'b0; res_a.period_ready = 1'b0;
        tick_b = 1'b0; clear_b = 1'b0; res_b.period_ready = 1'b0;
        #12;
        chk("rst_period",  64'(res_a.period), 64'd0);
        chk("rst_valid",   64'(res_a.period_valid), 64'd0);
        chk("rst_timeout", 64'(timeout_a), 64'd0);
        chk("rst_overrun", 64'(overrun_a), 64'd0);
`ifdef TICK_METER_STATS_EN
        chk("rst_min", 64'(min_b), 64'hFFFF_FFFF);
        chk("rst_max", 64'(max_b), 64'd0);
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Steady ticks every 5 cycles, consumer always ready.
        step_a(1, 0, 1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                step_a(0, 0, 1);
                if (i == 0) chk("steady_valid_low", 64'(res_a.period_valid), 64'd0);
            end
            exp_a.push_back(32'd5);
            step_a(1, 0, 1);
            chk("steady_valid_high", 64'(res_a.period_valid), 64'd1);
        end
        step_a(0, 0, 1);
        chk("steady_timeout", 64'(timeout_a), 64'd0);
        chk("steady_overrun", 64'(overrun_a), 64'd0);

        // Back-to-back ticks; second capture coincides with a transfer.
        exp_a.push_back(32'd2);
        step_a(1, 0, 1);
        exp_a.push_back(32'd1);
        step_a(1, 0, 1);
        chk("b2b_valid_held", 64'(res_a.period_valid), 64'd1);
        step_a(0, 0, 1);
        chk("b2b_overrun", 64'(overrun_a), 64'd0);
        step_a(0, 1, 0);

        // Overrun: ticks every 4 cycles, consumer not ready.
        step_a(1, 0, 0);
        repeat (3) step_a(0, 0, 0);
        exp_a.push_back(32'd4);
        step_a(1, 0, 0);
        repeat (3) step_a(0, 0, 0);
        chk("ovr_before", 64'(overrun_a), 64'd0);
        step_a(1, 0, 0);
        chk("ovr_set", 64'(overrun_a), 64'd1);
        chk("ovr_kept", 64'(res_a.period), 64'd4);
        step_a(0, 0, 1);
        chk("ovr_drained", 64'(res_a.period_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun_a), 64'd1);
        step_a(0, 1, 0);
        chk("ovr_cleared", 64'(overrun_a), 64'd0);

        // Timeout: one tick then silence; fires on the 8th silent edge.
        step_a(1, 0, 1);
        repeat (7) step_a(0, 0, 1);
        chk("to_not_yet", 64'(timeout_a), 64'd0);
        step_a(0, 0, 1);
        chk("to_set", 64'(timeout_a), 64'd1);
        step_a(1, 0, 1);
        chk("to_idle_no_result", 64'(res_a.period_valid), 64'd0);
        step_a(0, 1, 0);
        chk("to_cleared", 64'(timeout_a), 64'd0);

        // Tick exactly on the threshold cycle wins over the timeout.
        step_a(1, 0, 1);
        repeat (7) step_a(0, 0, 1);
        exp_a.push_back(32'd8);
        step_a(1, 0, 1);
        chk("thr_timeout", 64'(timeout_a), 64'd0);
        chk("thr_valid", 64'(res_a.period_valid), 64'd1);
        step_a(0, 0, 1);

        // Clear together with a tick mid-count: back to IDLE, no result.
        step_a(1, 1, 0);
        chk("clr_valid", 64'(res_a.period_valid), 64'd0);
        chk("clr_timeout", 64'(timeout_a), 64'd0);
        repeat (3) step_a(0, 0, 1);
        step_a(1, 0, 1);
        chk("clr_idle_no_result", 64'(res_a.period_valid), 64'd0);

        // Asynchronous reset between edges while a result and overrun are held.
        step_a(0, 0, 0);
        step_a(0, 0, 0);
        step_a(1, 0, 0);
        chk("rst2_valid_pre", 64'(res_a.period_valid), 64'd1);
        chk("rst2_period_pre", 64'(res_a.period), 64'd3);
        step_a(1, 0, 0);
        chk("rst2_overrun_pre", 64'(overrun_a), 64'd1);
        tick_a = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst2_period", 64'(res_a.period), 64'd0);
        chk("rst2_valid", 64'(res_a.period_valid), 64'd0);
        chk("rst2_overrun", 64'(overrun_a), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step_a(1, 0, 1);
        chk("rst2_idle_no_result", 64'(res_a.period_valid), 64'd0);
        step_a(0, 1, 0);

        // Longer periods 6, 3, 9 on dut_b (and stats when built in).
        step_b(1, 0, 1);
        repeat (5) step_b(0, 0, 1);
        exp_b.push_back(32'd6);
        step_b(1, 0, 1);
`ifdef TICK_METER_STATS_EN
        chk("st_min_first", 64'(min_b), 64'd6);
        chk("st_max_first", 64'(max_b), 64'd6);
`endif
        repeat (2) step_b(0, 0, 1);
        exp_b.push_back(32'd3);
        step_b(1, 0, 1);
        repeat (8) step_b(0, 0, 1);
        exp_b.push_back(32'd9);
        step_b(1, 0, 1);
        step_b(0, 0, 1);
`ifdef TICK_METER_STATS_EN
        chk("st_min", 64'(min_b), 64'd3);
        chk("st_max", 64'(max_b), 64'd9);
`endif
        step_b(0, 1, 0);
`ifdef TICK_METER_STATS_EN
        chk("st_min_clr", 64'(min_b), 64'hFFFF_FFFF);
        chk("st_max_clr", 64'(max_b), 64'd0);
`endif
        chk("b_timeout", 64'(timeout_b), 64'd0);
        chk("b_overrun", 64'(overrun_b), 64'd0);

        chk("a_sb_empty", 64'(exp_a.size()), 64'd0);
        chk("b_sb_empty", 64'(exp_b.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
